// File: rtl/ilm_dot_accum.sv
// ilm_dot_accum: streaming saturating dot-product accumulator.
// Sums each group of LEN unsigned 32-bit products from the ILM_AE multiplier
// wrapper into one ACC_W-bit result. The finished sum is held until the
// consumer takes it.
//
// state | meaning
// ------+---------------------------------------------------------------
// ACC   | accepting products, p_ready=1, partial sum building in r_acc
// OUT   | finished sum held on o_sum_out, o_sum_valid=1, inputs ignored
module ilm_dot_accum #(
  parameter  int LEN   = 8,
  parameter  int ACC_W = 34,
  localparam int CW    = $clog2(LEN + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic [31:0]      i_p_in,
  input  logic             i_p_valid,
  output logic             o_p_ready,
  output logic [ACC_W-1:0] o_sum_out,
  output logic             o_sum_valid,
  input  logic             i_sum_ready,
  output logic             o_sat,
  output logic [CW-1:0]    o_cnt_out
);

  localparam logic [0:0] S_ACC = 1'b0;
  localparam logic [0:0] S_OUT = 1'b1;

  logic [0:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_sat;

  logic [ACC_W:0]   w_sum;
  logic             w_ovf;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_accept;
  logic             w_last;

  // Saturating add of the offered product; one extra bit catches the carry-out.
  always_comb begin
    w_sum     = {1'b0, r_acc} + (ACC_W + 1)'(i_p_in);
    w_ovf     = w_sum[ACC_W];
    w_acc_nxt = w_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    w_accept  = i_p_valid && (r_state == S_ACC);
    w_last    = (r_cnt == CW'(LEN - 1));
  end

  // Group state: clear beats acceptance and release; reset acts immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_ACC;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else if (i_clear) begin
      r_state <= S_ACC;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        S_ACC: begin
          if (w_accept) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
            r_sat <= r_sat | w_ovf;
            if (w_last) r_state <= S_OUT;
          end
        end
        S_OUT: begin
          if (i_sum_ready) begin
            r_state <= S_ACC;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
          end
        end
        default: r_state <= S_ACC;
      endcase
    end
  end

  // Outputs come only from registers so nothing on the input side reaches them.
  always_comb begin
    o_p_ready   = (r_state == S_ACC);
    o_sum_valid = (r_state == S_OUT);
    o_sum_out   = r_acc;
    o_sat       = r_sat;
    o_cnt_out   = r_cnt;
  end

endmodule

// File: tb/tb_ilm_dot_accum.sv
// Directed bench for ilm_dot_accum (LEN=8, ACC_W=34).
// Inputs change and outputs are checked on the falling edge.
module tb_ilm_dot_accum;

  localparam int LEN   = 8;
  localparam int ACC_W = 34;
  localparam int CW    = $clog2(LEN + 1);

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic [31:0]      p_in;
  logic             p_valid;
  logic             p_ready;
  logic [ACC_W-1:0] sum_out;
  logic             sum_valid;
  logic             sum_ready;
  logic             sat;
  logic [CW-1:0]    cnt_out;

  int n_cmp = 0;
  int n_err = 0;

  ilm_dot_accum #(.LEN(LEN), .ACC_W(ACC_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_clear     (clear),
    .i_p_in      (p_in),
    .i_p_valid   (p_valid),
    .o_p_ready   (p_ready),
    .o_sum_out   (sum_out),
    .o_sum_valid (sum_valid),
    .i_sum_ready (sum_ready),
    .o_sat       (sat),
    .o_cnt_out   (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Offer one product for one edge; starts and ends at a falling edge.
  task automatic send(input logic [31:0] v);
    p_valid = 1'b1;
    p_in    = v;
    @(posedge clk);
    @(negedge clk);
    p_valid = 1'b0;
  endtask

  task automatic release_sum();
    sum_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [63:0] s, input logic st);
    chk({tag, ".valid"}, 64'(sum_valid), 64'd1);
    chk({tag, ".sum"},   64'(sum_out),   s);
    chk({tag, ".sat"},   64'(sat),       64'(st));
    chk({tag, ".cnt"},   64'(cnt_out),   64'd8);
    chk({tag, ".ready"}, 64'(p_ready),   64'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ready"}, 64'(p_ready),   64'd1);
    chk({tag, ".valid"}, 64'(sum_valid), 64'd0);
    chk({tag, ".cnt"},   64'(cnt_out),   64'd0);
    chk({tag, ".sum"},   64'(sum_out),   64'd0);
    chk({tag, ".sat"},   64'(sat),       64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pat;
    int          acc_n;
    int          cyc;

    rst_n = 1'b0; clear = 1'b0; p_in = '0; p_valid = 1'b0; sum_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_low.valid", 64'(sum_valid), 64'd0);
    chk("rst_low.sum",   64'(sum_out),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("reset");

    // Group 1: 1..8 back-to-back -> 36, one-cycle bubble, then 8 x 0x10 -> 128
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) chk("g1.pre8_valid", 64'(sum_valid), 64'd0);
      send(32'(i));
    end
    chk_out("g1", 64'd36, 1'b0);
    release_sum();
    chk_idle("g1.bubble_end");
    for (int i = 0; i < 8; i++) send(32'h10);
    chk_out("g2", 64'd128, 1'b0);
    release_sum();

    // Saturation: sat flips on the 5th 0xFFFF_FFFF, result pinned at max
    for (int i = 0; i < 8; i++) begin
      send(32'hFFFF_FFFF);
      if (i == 3) chk("sat.after4", 64'(sat), 64'd0);
      if (i == 4) chk("sat.after5", 64'(sat), 64'd1);
    end
    chk_out("sat", 64'h3_FFFF_FFFF, 1'b1);
    release_sum();
    chk_idle("sat.release");
    for (int i = 0; i < 8; i++) send(32'd1);
    chk_out("after_sat", 64'd8, 1'b0);
    release_sum();

    // Backpressure: result held 5 cycles while products keep arriving
    sum_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'd3);
    chk_out("bp", 64'd24, 1'b0);
    for (int k = 0; k < 5; k++) begin
      p_valid = 1'b1;
      p_in    = 32'(k * 7 + 1);
      @(posedge clk);
      @(negedge clk);
      chk_out("bp.hold", 64'd24, 1'b0);
    end
    p_valid = 1'b0;
    release_sum();
    for (int i = 1; i <= 8; i++) send(32'(i));
    chk_out("bp.next", 64'd36, 1'b0);
    release_sum();

    // Input gaps: valid pattern 1,0,1,1,0,0,1,... (LSB first)
    pat   = 16'b1010_0110_0100_1101;
    acc_n = 0;
    cyc   = 0;
    while (acc_n < 8 && cyc < 40) begin
      if (pat[cyc % 16]) begin
        send(32'(acc_n + 1));
        acc_n++;
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
      cyc++;
    end
    chk("gaps.accepted", 64'(acc_n), 64'd8);
    chk_out("gaps", 64'd36, 1'b0);
    release_sum();

    // Clear: 3 x 100, then clear with a valid 50 in the same cycle
    for (int i = 0; i < 3; i++) send(32'd100);
    chk("clr.cnt3", 64'(cnt_out), 64'd3);
    chk("clr.sum3", 64'(sum_out), 64'd300);
    clear = 1'b1;
    send(32'd50);
    clear = 1'b0;
    chk_idle("clr");
    for (int i = 0; i < 8; i++) send(32'd2);
    chk_out("clr.next", 64'd16, 1'b0);

    // Async reset while holding a result
    sum_ready = 1'b0;
    @(posedge clk);
    #2;
    chk("ar.pre_valid", 64'(sum_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("ar.valid", 64'(sum_valid), 64'd0);
    chk("ar.sum",   64'(sum_out),   64'd0);
    chk("ar.sat",   64'(sat),       64'd0);
    chk("ar.cnt",   64'(cnt_out),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sum_ready = 1'b1;
    #1;
    chk("ar.ready", 64'(p_ready), 64'd1);
    @(negedge clk);
    for (int i = 0; i < 8; i++) send(32'd5);
    chk_out("ar.next", 64'd40, 1'b0);
    release_sum();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
